// File: rtl/uart_tx.sv
// +-----------------------------------------------------------------------------
// | Module      : uart_tx
// | Description : FIFO-fed 8-bit UART transmitter with optional parity and 1/2 stop bits.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
  parameter int DIV_W = 16
) (
  input  logic             g_clk,
  input  logic             g_reset,
  output logic             g_clk_req,
  input  logic [DIV_W-1:0] cfg_clk_div,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_pop,
  output logic             uart_txd,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             stop2_q, stop2_d;
  logic             stop_hi_q, stop_hi_d;
  logic             txd_q, txd_d;

  logic [DIV_W-1:0] w_div_eff;
  logic [2:0]       w_idx_nxt;
  logic             w_bit_end;
  logic             w_stop_last;
  logic             w_accept;

  always_comb begin
    w_div_eff   = (cfg_clk_div == '0) ? DIV_W'(1) : cfg_clk_div;
    w_idx_nxt   = idx_q + 3'd1;
    w_bit_end   = (cnt_q == '0);
    // stop_hi_q marks that the first of two stop bits has already elapsed
    w_stop_last = (state_q == STOP) && w_bit_end && (!stop2_q || stop_hi_q);
    w_accept    = !g_reset && in_valid && ((state_q == IDLE) || w_stop_last);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop2_d   = stop2_q;
    stop_hi_d = stop_hi_q;
    txd_d     = txd_q;

    if (state_q != IDLE && !w_bit_end) begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    case (state_q)
      START: begin
        if (w_bit_end) begin
          state_d = DATA;
          cnt_d   = div_q - DIV_W'(1);
          idx_d   = 3'd0;
          txd_d   = data_q[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          cnt_d = div_q - DIV_W'(1);
          if (idx_q == 3'd7) begin
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = (^data_q) ^ par_odd_q;
            end else begin
              state_d   = STOP;
              txd_d     = 1'b1;
              stop_hi_d = 1'b0;
            end
          end else begin
            idx_d = w_idx_nxt;
            txd_d = data_q[w_idx_nxt];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          state_d   = STOP;
          cnt_d     = div_q - DIV_W'(1);
          txd_d     = 1'b1;
          stop_hi_d = 1'b0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (w_stop_last) begin
            state_d = IDLE;
          end else begin
            stop_hi_d = 1'b1;
            cnt_d     = div_q - DIV_W'(1);
          end
        end
      end
      default: begin
        txd_d = 1'b1;
      end
    endcase

    // Acceptance overrides the end-of-frame return to IDLE for back-to-back bytes
    if (w_accept) begin
      state_d   = START;
      data_d    = in_data;
      div_d     = w_div_eff;
      par_en_d  = cfg_parity_en;
      par_odd_d = cfg_parity_odd;
      stop2_d   = cfg_stop2;
      stop_hi_d = 1'b0;
      idx_d     = 3'd0;
      cnt_d     = w_div_eff - DIV_W'(1);
      txd_d     = 1'b0;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      txd_q     <= txd_d;
    end
  end

  assign uart_txd  = txd_q;
  assign busy      = (state_q != IDLE);
  assign g_clk_req = busy || in_valid;
  assign in_pop    = w_accept;

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Parameters
REQ-001 The module SHALL have parameter DIV_W, default 16, giving the width of the bit-period divisor.

Interface
REQ-002 g_clk  input  1  Single clock; all state SHALL be updated on its rising edge.
REQ-003 g_reset  input  1  Asynchronous, active-high reset.
REQ-004 g_clk_req  output  1  Clock request: high while not IDLE or while in_valid is high.
REQ-005 cfg_clk_div  input  DIV_W  g_clk cycles per serial bit; 0 is treated as 1.
REQ-006 cfg_parity_en  input  1  Parity bit enable.
REQ-007 cfg_parity_odd  input  1  1 selects odd parity, 0 selects even parity.
REQ-008 cfg_stop2  input  1  1 selects two stop bits, 0 selects one.
REQ-009 in_valid  input  1  Upstream TX FIFO holds a byte (FIFO out_valid).
REQ-010 in_data  input  8  Upstream byte (FIFO out_data), stable while in_valid.
REQ-011 in_pop  output  1  One-cycle pulse consuming the byte (FIFO pop).
REQ-012 uart_txd  output  1  Serial line, idle high.
REQ-013 busy  output  1  High whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-015 A byte SHALL be accepted in the cycle where in_pop is high; in_pop SHALL be high iff in_valid and (state==IDLE, or state==STOP in its final cycle).
REQ-016 On acceptance, in_data, cfg_clk_div (0 mapped to 1), cfg_parity_en, cfg_parity_odd and cfg_stop2 SHALL be latched; cfg changes mid-frame SHALL have no effect on that frame.
REQ-017 The cycle after acceptance, state SHALL be START and uart_txd SHALL be 0.
REQ-018 Each bit SHALL last exactly D = latched divisor g_clk cycles, timed by a DIV_W-bit down-counter loaded with D-1 at each bit start; the bit ends in the cycle the counter is 0.
REQ-019 DATA SHALL send 8 bits LSB first, tracked by a 3-bit index; it leaves DATA after bit 7.
REQ-020 After DATA the state SHALL go to PARITY if parity is enabled, else to STOP.
REQ-021 The parity bit SHALL be the XOR of the 8 data bits, inverted when cfg_parity_odd is 1.
REQ-022 STOP SHALL drive uart_txd=1 for D cycles, or 2*D cycles when cfg_stop2 is 1.
REQ-023 At the end of STOP the state SHALL go to START when a byte is accepted that cycle (back-to-back, no idle gap), else to IDLE.
REQ-024 uart_txd SHALL be driven from a register, with no combinational path from any input.
REQ-025 in_pop SHALL never be high for two consecutive cycles within one frame, and never be high while in_valid is low.
REQ-026 Frame length SHALL be (10 + parity_en + stop2)*D cycles.

Reset
REQ-027 While g_reset is high: state=IDLE, uart_txd=1, in_pop=0, busy=0, and all counters and latches are 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously, with uart_txd returning to 1; the aborted byte SHALL NOT be re-sent.
REQ-029 After reset deasserts, the first acceptance SHALL occur no earlier than the first rising edge at which g_reset is low.

Verification
REQ-030 The bench SHALL cover basic frame: D=4, 8N1, in_data=0xA5 -> in_pop one cycle; txd = 0, then 1,0,1,0,0,1,0,1, then 1, each 4 cycles; busy for 40 cycles.
REQ-031 The bench SHALL cover parity and stop: D=2, parity even, stop2, data=0x07 -> parity bit 1; stop high 4 cycles; frame 24 cycles; odd parity -> parity bit 0.
REQ-032 The bench SHALL cover back-to-back: FIFO holds 0x55, 0xAA with D=3 -> the second start bit begins the cycle after the last stop cycle; two pops exactly 30 cycles apart.
REQ-033 The bench SHALL cover divisor zero: cfg_clk_div=0, data=0xFF -> each bit lasts 1 cycle; frame 10 cycles.
REQ-034 The bench SHALL cover config change: switch cfg_clk_div 4->8 during DATA -> the current frame stays at 4 cycles per bit; the next frame uses 8.
REQ-035 The bench SHALL cover reset mid-frame: assert g_reset during DATA bit 3 -> txd=1 and busy=0 asynchronously; with in_valid=1 after release, a new pop occurs and a full new frame follows.
